// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD calculator sequencer:
// state encoding, key codes and ALU operation encodings.
package calc_pkg;

  localparam int N_DIGITS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_EXEC     = 3'd2,
    ST_SHOW_RES = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } alu_op_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;

  function automatic alu_op_t key_to_op(input logic [3:0] code);
    case (code)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Key-event, ALU handshake and display bundle of the calculator sequencer.
// The master side is the sequencer; the slave side is keypad/ALU/display.
interface calc_sequencer_if #(
  parameter int N_DIGITS = calc_pkg::N_DIGITS_DEFAULT
);
  localparam int W = 4 * N_DIGITS;

  logic         key_valid;
  logic [3:0]   key_code;
  logic         alu_start;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_err;
  logic [W-1:0] disp_value;
  logic [2:0]   disp_len;
  logic         err_flag;
  logic         busy;
  logic [2:0]   state_dbg;

  modport master (
    input  key_valid, key_code, alu_done, alu_result, alu_err,
    output alu_start, alu_op, alu_a, alu_b, disp_value, disp_len,
           err_flag, busy, state_dbg
  );

  modport slave (
    output key_valid, key_code, alu_done, alu_result, alu_err,
    input  alu_start, alu_op, alu_a, alu_b, disp_value, disp_len,
           err_flag, busy, state_dbg
  );

endinterface

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: shifts digits in from the right up to N_DIGITS,
// with clear and preset. Next-state values are exported for registered display.
module bcd_entry_reg #(
  parameter int N_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [3:0]                    digit,
  input  logic                          clear,
  input  logic                          preset,
  input  logic [4*N_DIGITS-1:0]         preset_value,
  input  logic [$clog2(N_DIGITS+1)-1:0] preset_count,
  output logic [4*N_DIGITS-1:0]         value,
  output logic [$clog2(N_DIGITS+1)-1:0] count,
  output logic                          full,
  output logic [4*N_DIGITS-1:0]         value_next,
  output logic [$clog2(N_DIGITS+1)-1:0] count_next
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  assign full = (count == CW'(N_DIGITS));

  // Clear beats preset beats digit shift; digits past a full operand are dropped.
  always_comb begin
    value_next = value;
    count_next = count;
    if (clear) begin
      value_next = '0;
      count_next = '0;
    end else if (preset) begin
      value_next = preset_value;
      count_next = preset_count;
    end else if (load && !full) begin
      value_next = {value[W-5:0], digit};
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-ALU sequencer for the BCD calculator: builds A, op, B, runs the ALU
// and drives the display. Define CALC_CHAIN_EN to chain an operator onto a result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEFAULT,
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              reset,
  calc_sequencer_if.master bus
);
  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic is_digit, is_op, is_clear, is_eq;

  assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign is_op    = bus.key_valid && ((bus.key_code == KEY_ADD) ||
                    (bus.key_code == KEY_SUB) || (bus.key_code == KEY_MUL));
  assign is_clear = bus.key_valid && (bus.key_code == KEY_CLR);
  assign is_eq    = bus.key_valid && (bus.key_code == KEY_EQ);

  state_t        state, state_n;
  alu_op_t       op, op_n;
  logic [W-1:0]  result, result_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          start_n;
  logic [W-1:0]  disp_q, disp_n;
  logic [2:0]    len_q, len_n;
  logic          start_q, err_q, busy_q;

  logic          a_load, a_clear, a_preset, a_full, b_load, b_clear, b_full;
  logic [W-1:0]  a_preset_val, a_val, a_val_n, b_val, b_val_n;
  logic [CW-1:0] a_preset_cnt, a_cnt, a_cnt_n, b_cnt, b_cnt_n;

  bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_entry_a (
    .clk(clk), .reset(reset), .load(a_load), .digit(bus.key_code),
    .clear(a_clear), .preset(a_preset), .preset_value(a_preset_val),
    .preset_count(a_preset_cnt), .value(a_val), .count(a_cnt), .full(a_full),
    .value_next(a_val_n), .count_next(a_cnt_n)
  );

  bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_entry_b (
    .clk(clk), .reset(reset), .load(b_load), .digit(bus.key_code),
    .clear(b_clear), .preset(1'b0), .preset_value('0),
    .preset_count('0), .value(b_val), .count(b_cnt), .full(b_full),
    .value_next(b_val_n), .count_next(b_cnt_n)
  );

  function automatic logic [2:0] sig_len(input logic [W-1:0] v);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) n = 3'(i + 1);
    end
    return n;
  endfunction

  // Clear pre-empts everything, including an ALU completion in the same cycle.
  always_comb begin
    state_n      = state;
    op_n         = op;
    result_n     = result;
    tmo_n        = tmo;
    start_n      = 1'b0;
    a_load       = 1'b0;
    a_clear      = 1'b0;
    a_preset     = 1'b0;
    a_preset_val = '0;
    a_preset_cnt = '0;
    b_load       = 1'b0;
    b_clear      = 1'b0;
    if (is_clear) begin
      state_n  = ST_ENTER_A;
      op_n     = OP_ADD;
      result_n = '0;
      tmo_n    = '0;
      a_clear  = 1'b1;
      b_clear  = 1'b1;
    end else begin
      case (state)
        ST_ENTER_A: begin
          if (is_digit) begin
            a_load = !a_full;
          end else if (is_op && (a_cnt != '0)) begin
            op_n    = key_to_op(bus.key_code);
            state_n = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (is_digit) begin
            b_load = !b_full;
          end else if (is_op && (b_cnt == '0)) begin
            op_n = key_to_op(bus.key_code);
          end else if (is_eq && (b_cnt != '0)) begin
            state_n = ST_EXEC;
            start_n = 1'b1;
            tmo_n   = '0;
          end
        end
        // A done arriving on the timeout cycle still delivers its result.
        ST_EXEC: begin
          if (bus.alu_done) begin
            if (bus.alu_err) begin
              state_n = ST_ERROR;
            end else begin
              result_n = bus.alu_result;
              state_n  = ST_SHOW_RES;
            end
          end else if (tmo == TMO_LAST) begin
            state_n = ST_ERROR;
          end else begin
            tmo_n = tmo + 1'b1;
          end
        end
        ST_SHOW_RES: begin
          if (is_digit) begin
            a_preset     = 1'b1;
            a_preset_val = W'(bus.key_code);
            a_preset_cnt = CW'(1);
            b_clear      = 1'b1;
            op_n         = OP_ADD;
            state_n      = ST_ENTER_A;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            a_preset     = 1'b1;
            a_preset_val = result;
            a_preset_cnt = CW'(N_DIGITS);
            b_clear      = 1'b1;
            op_n         = key_to_op(bus.key_code);
            state_n      = ST_ENTER_B;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Display follows the state being entered so it is valid one cycle after a key.
  always_comb begin
    disp_n = disp_q;
    len_n  = len_q;
    case (state_n)
      ST_ENTER_A: begin
        disp_n = a_val_n;
        len_n  = 3'(a_cnt_n);
      end
      ST_ENTER_B: begin
        disp_n = (b_cnt_n == '0) ? a_val_n : b_val_n;
        len_n  = (b_cnt_n == '0) ? 3'(a_cnt_n) : 3'(b_cnt_n);
      end
      ST_SHOW_RES: begin
        disp_n = result_n;
        len_n  = sig_len(result_n);
      end
      ST_ERROR: begin
        disp_n = '0;
        len_n  = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_ENTER_A;
      op      <= OP_ADD;
      result  <= '0;
      tmo     <= '0;
      start_q <= 1'b0;
      disp_q  <= '0;
      len_q   <= 3'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      op      <= op_n;
      result  <= result_n;
      tmo     <= tmo_n;
      start_q <= start_n;
      disp_q  <= disp_n;
      len_q   <= len_n;
      err_q   <= (state_n == ST_ERROR);
      busy_q  <= (state_n == ST_EXEC);
    end
  end

  assign bus.alu_start  = start_q;
  assign bus.alu_op     = op;
  assign bus.alu_a      = a_val;
  assign bus.alu_b      = b_val;
  assign bus.disp_value = disp_q;
  assign bus.disp_len   = len_q;
  assign bus.err_flag   = err_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed keypad scenarios followed by
// random key/ALU traffic, compared against a behavioural calculator model.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int N   = 4;
  localparam int W   = 4 * N;
  localparam int TMO = 255;

  localparam int P_A = 0, P_B = 1, P_X = 2, P_S = 3, P_E = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_sequencer_if #(.N_DIGITS(N)) bus ();

  calc_sequencer #(.N_DIGITS(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int           m_phase, m_cnta, m_cntb, m_op, m_len, m_exec;
  logic [W-1:0] m_a, m_b, m_res, m_disp;
  bit           m_start;

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input int d);
    int t;
    t = int'(v) * 16 + d;
    return W'(t % (1 << W));
  endfunction

  function automatic int digits_of(input logic [W-1:0] v);
    int n;
    int t;
    n = 0;
    t = int'(v);
    while (t != 0) begin
      n++;
      t = t / 16;
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic state_t phase_state(input int p);
    case (p)
      P_B:     return ST_ENTER_B;
      P_X:     return ST_EXEC;
      P_S:     return ST_SHOW_RES;
      P_E:     return ST_ERROR;
      default: return ST_ENTER_A;
    endcase
  endfunction

  task automatic model_clear();
    m_phase = P_A;
    m_a = '0; m_b = '0; m_res = '0; m_disp = '0;
    m_cnta = 0; m_cntb = 0; m_op = 0; m_len = 0; m_exec = 0;
    m_start = 1'b0;
  endtask

  task automatic model_edge(input bit kv, input int kc, input bit dn,
                            input logic [W-1:0] res, input bit er);
    bit dig, op, clr, eq;
    dig = kv && (kc <= 9);
    op  = kv && (kc >= 10) && (kc <= 12);
    clr = kv && (kc == 13);
    eq  = kv && (kc == 14);
    m_start = 1'b0;
    if (clr) begin
      model_clear();
    end else begin
      case (m_phase)
        P_A: begin
          if (dig && m_cnta < N) begin
            m_a = shift_in(m_a, kc);
            m_cnta++;
          end else if (op && m_cnta > 0) begin
            m_op = kc - 10;
            m_phase = P_B;
          end
        end
        P_B: begin
          if (dig && m_cntb < N) begin
            m_b = shift_in(m_b, kc);
            m_cntb++;
          end else if (op && m_cntb == 0) begin
            m_op = kc - 10;
          end else if (eq && m_cntb > 0) begin
            m_phase = P_X;
            m_exec = 0;
            m_start = 1'b1;
          end
        end
        P_X: begin
          if (dn) begin
            if (er) m_phase = P_E;
            else begin
              m_res = res;
              m_phase = P_S;
            end
          end else begin
            m_exec++;
            if (m_exec == TMO) m_phase = P_E;
          end
        end
        P_S: begin
          if (dig) begin
            m_a = W'(kc); m_cnta = 1;
            m_b = '0; m_cntb = 0; m_op = 0;
            m_phase = P_A;
          end
`ifdef CALC_CHAIN_EN
          else if (op) begin
            m_a = m_res; m_cnta = N;
            m_b = '0; m_cntb = 0; m_op = kc - 10;
            m_phase = P_B;
          end
`endif
        end
        default: ;
      endcase
    end
    case (m_phase)
      P_A: begin m_disp = m_a; m_len = m_cnta; end
      P_B: begin
        m_disp = (m_cntb == 0) ? m_a : m_b;
        m_len  = (m_cntb == 0) ? m_cnta : m_cntb;
      end
      P_S: begin m_disp = m_res; m_len = digits_of(m_res); end
      P_E: begin m_disp = '0; m_len = 0; end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".disp_value"}, 32'(bus.disp_value), 32'(m_disp));
    check({tag, ".disp_len"},   32'(bus.disp_len),   32'(m_len));
    check({tag, ".err_flag"},   32'(bus.err_flag),   32'(m_phase == P_E));
    check({tag, ".busy"},       32'(bus.busy),       32'(m_phase == P_X));
    check({tag, ".alu_start"},  32'(bus.alu_start),  32'(m_start));
    check({tag, ".alu_a"},      32'(bus.alu_a),      32'(m_a));
    check({tag, ".alu_b"},      32'(bus.alu_b),      32'(m_b));
    check({tag, ".alu_op"},     32'(bus.alu_op),     32'(m_op));
    check({tag, ".state"},      32'(bus.state_dbg),  32'(phase_state(m_phase)));
  endtask

  task automatic apply_stimulus(input string tag, input bit kv, input int kc,
                                input bit dn, input logic [W-1:0] res, input bit er);
    bus.key_valid  = kv;
    bus.key_code   = 4'(kc);
    bus.alu_done   = dn;
    bus.alu_result = res;
    bus.alu_err    = er;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.alu_done  = 1'b0;
    model_edge(kv, kc, dn, res, er);
    check_output(tag);
  endtask

  task automatic key(input string tag, input int kc);
    apply_stimulus(tag, 1'b1, kc, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input string tag);
    apply_stimulus(tag, 1'b0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic done(input string tag, input logic [W-1:0] res, input bit er);
    apply_stimulus(tag, 1'b0, 0, 1'b1, res, er);
  endtask

  initial begin
    logic [W-1:0] rres;
    bit kv, dn, er;
    int kc;

    reset          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    bus.alu_err    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset");
    reset = 1'b0;

    // 12 + 3 = with a delayed ALU completion
    key("t1_d1", 1); key("t1_d2", 2); key("t1_add", 10);
    key("t1_d3", 3); key("t1_eq", 14);
    repeat (4) idle("t1_wait");
    done("t1_done", 16'h0015, 1'b0);
    idle("t1_show");

    // fifth digit dropped
    key("t2_clr", 13);
    key("t2_d1", 1); key("t2_d2", 2); key("t2_d3", 3);
    key("t2_d4", 4); key("t2_d5", 5);

    // operator replacement before B, ignored after B
    key("t3_clr", 13);
    key("t3_d7", 7); key("t3_sub", 11); key("t3_add", 10);
    key("t3_d2", 2); key("t3_add2", 10); key("t3_sub2", 11);
    key("t3_eq", 14);
    done("t3_done", 16'h0009, 1'b0);

    // ALU error, digits ignored in ERROR, clear recovers
    key("t4_clr", 13);
    key("t4_d9", 9); key("t4_mul", 12); key("t4_d9b", 9); key("t4_eq", 14);
    idle("t4_wait");
    done("t4_err", 16'h0081, 1'b1);
    key("t4_dig", 5); key("t4_op", 10); key("t4_eq2", 14);
    key("t4_clr2", 13);

    // ALU never answers
    key("t5_d5", 5); key("t5_add", 10); key("t5_d5b", 5); key("t5_eq", 14);
    repeat (TMO + 2) idle("t5_tmo");
    key("t5_dig", 3);
    key("t5_clr", 13);

    // clear with coincident done, then a stray done outside EXEC
    key("t6_d4", 4); key("t6_add", 10); key("t6_d4b", 4); key("t6_eq", 14);
    idle("t6_wait");
    apply_stimulus("t6_clrdone", 1'b1, 13, 1'b1, 16'h0008, 1'b0);
    idle("t6_idle");
    done("t6_stray", 16'h9999, 1'b0);

    // operator after a result, then continue
    key("t7_d1", 1); key("t7_add", 10); key("t7_d1b", 1); key("t7_eq", 14);
    done("t7_done", 16'h0015, 1'b0);
    key("t7_op", 10);
    key("t7_d6", 6);
    key("t7_eq", 14);
    done("t7_done2", 16'h0021, 1'b0);

    // zero result, operator/equals on empty A
    key("t8_clr", 13);
    key("t8_op", 10); key("t8_eq", 14);
    key("t8_d0", 0); key("t8_add", 10); key("t8_d0b", 0); key("t8_eqb", 14);
    done("t8_zero", 16'h0000, 1'b0);

    // random keys and ALU responses
    for (int i = 0; i < 300; i++) begin
      kv = ($urandom_range(0, 2) == 0);
      kc = $urandom_range(0, 15);
      if (kc == 13 && $urandom_range(0, 3) != 0) kc = 14;
      if (m_phase == P_E && $urandom_range(0, 5) == 0) begin
        kv = 1'b1;
        kc = 13;
      end
      dn = (m_phase == P_X) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      er = ($urandom_range(0, 4) == 0);
      rres = '0;
      for (int d = 0; d < N; d++) begin
        rres = shift_in(rres, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 9));
      end
      apply_stimulus("rand", kv, kc, dn, rres, er);
    end

    // asynchronous reset in the middle of EXEC
    key("t9_clr", 13);
    key("t9_d2", 2); key("t9_add", 10); key("t9_d3", 3); key("t9_eq", 14);
    idle("t9_wait");
    reset = 1'b1;
    #1;
    model_clear();
    check_output("t9_async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("t9_rst_held");
    key("t9_after", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level keypad-to-ALU sequencer for the 4-digit BCD calculator. Consumes debounced one-cycle key events and builds operand A, operator and operand B. Launches the ALU with a start/done handshake and drives the display value. It sits between the key-entry FSM (digit pulses, digit count) and the arithmetic datapath/7-segment driver.

Parameters:
N_DIGITS, 4, BCD digits per operand/result; operand width = 4*N_DIGITS
TIMEOUT_CYC, 255, max cycles EXEC waits for alu_done before ERROR (counter width = clog2(TIMEOUT_CYC+1))

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state/outputs
key_valid  in  1  one-cycle pulse, key_code valid
key_code  in  4  0-9 digit, A=add, B=sub, C=mul, D=clear, E=equals, F=ignored
alu_start  out  1  one-cycle pulse launching ALU
alu_op  out  2  00 add, 01 sub, 10 mul; held stable EXEC..done
alu_a  out  4*N_DIGITS  operand A, BCD
alu_b  out  4*N_DIGITS  operand B, BCD
alu_done  in  1  one-cycle pulse, alu_result/alu_err valid
alu_result  in  4*N_DIGITS  BCD result
alu_err  in  1  overflow/negative/invalid, sampled with alu_done
disp_value  out  4*N_DIGITS  BCD value to display
disp_len  out  3  significant digits shown (0 = blank); leading digits blanked
err_flag  out  1  high in ERROR
busy  out  1  high in EXEC
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async): state ENTER_A; operands, op, counts, result, timeout counter = 0; all outputs 0.
- States: ENTER_A, ENTER_B, EXEC, SHOW_RES, ERROR. Registered state; outputs registered, valid the cycle after the event.
- Clear key (D): highest priority in every state. Zeroes operands/counts/op/result and goes to ENTER_A next cycle. A coincident alu_done is discarded.
- ENTER_A, digit: if cnt_a < N_DIGITS then A <= {A[4*N_DIGITS-5:0], digit}, cnt_a++; 5th+ digit ignored. Leading 0 counts as a digit.
- ENTER_A, operator: if cnt_a == 0, ignore; else latch op -> ENTER_B. Equals ignored.
- ENTER_B, digit: same shift rule on B/cnt_b.
- ENTER_B, operator: if cnt_b == 0, replace op; else ignore.
- ENTER_B, equals: if cnt_b > 0 -> EXEC; else ignore.
- EXEC entry: alu_start = 1 for exactly the first EXEC cycle; alu_a/alu_b/alu_op frozen. Non-clear keys ignored.
- EXEC, alu_done & !alu_err: latch result -> SHOW_RES.
- EXEC, alu_done & alu_err -> ERROR.
- EXEC timeout: counter increments per EXEC cycle; reaching TIMEOUT_CYC without done -> ERROR. Done in the same cycle as timeout wins.
- alu_done outside EXEC is ignored.
- SHOW_RES, digit: zero A/B/op, A <= digit, cnt_a = 1 -> ENTER_A. Operator: see optional feature. Equals ignored.
- ERROR: err_flag = 1, disp_len = 0. Only clear exits.
- Display: ENTER_A shows A/cnt_a. ENTER_B shows B/cnt_b, but shows A/cnt_a while cnt_b == 0. EXEC holds the previous display. SHOW_RES shows result with disp_len = index of highest nonzero digit + 1 (min 1).
- key_code F and undefined combinations: no effect.

Optional Feature:
CALC_CHAIN_EN
- Defined: operator key in SHOW_RES loads A <= result, cnt_a = N_DIGITS, latches op, clears B/cnt_b -> ENTER_B (chained calculation).
- Undefined: operator in SHOW_RES is ignored; a new calculation requires a digit or clear.

Decomposition:
- Package calc_pkg: state encoding constants, key code constants (KEY_ADD..KEY_EQ), alu_op encodings, N_DIGITS default.
- Sub-module bcd_entry_reg, instantiated twice (A, B). Inputs: load digit, clear, preset value/count. Outputs: value, count, full flag.

Test Plan:
- 1,2,+,3,= with alu_done after 5 cycles, result 0x0015 -> single alu_start pulse, alu_a=0x0012, alu_b=0x0003, alu_op=00; disp_value=0x0015, disp_len=2.
- Enter 1,2,3,4,5 -> A=0x1234, cnt_a=4, 5th digit ignored; disp_len=4.
- 7,-,+,2,= -> op replaced, alu_op=00; then +,- after digit 2 -> op unchanged.
- 9,*,9,= with alu_err=1 on done -> ERROR, err_flag=1; digits ignored; clear -> ENTER_A, all zero.
- = with no alu_done for TIMEOUT_CYC cycles -> ERROR. Separately: clear during EXEC plus coincident done -> ENTER_A, result not latched.
- Assert reset mid-EXEC -> all outputs 0 immediately. With CALC_CHAIN_EN, result 0x0015 then + -> A=0x0015, state ENTER_B; without it, state stays SHOW_RES.
